// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game sequencer.
// States, serve directions and the default winning score.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_WAIT_UPD = 3'd3,
    ST_POINT    = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int WIN_SCORE_DEF = 5;

endpackage

// File: rtl/pong_edge_det.sv
// Registered rising-edge detector for a debounced button level.
// A press is current level high while the registered level is low.
module pong_edge_det
  import pong_pkg::*;
(
  input  logic clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb d_d = d;

  always_ff @(posedge clk) begin
    if (Reset) d_q <= 1'b0;
    else       d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-level serve/play/point/game-over sequencer for pong.
// Define PONG_AUTOSERVE_EN to leave SERVE after SERVE_FRAMES ticks.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               BTN_NORT,
  input  logic               upd_done,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               upd_en,
  output logic               ball_center,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               frame_overrun,
  output logic [2:0]         state_o
);

  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic               upd_q, upd_d;
  logic               bc_q, bc_d;
  logic               dir_q, dir_d;
  logic [SCORE_W-1:0] sl_q, sl_d;
  logic [SCORE_W-1:0] sr_q, sr_d;
  logic               go_q, go_d;
  logic               ovr_q, ovr_d;
  logic               pend_q, pend_d;
  logic               press;
  logic               tick_ok;
  logic               tick_bad;

`ifdef PONG_AUTOSERVE_EN
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(SERVE_FRAMES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  pong_edge_det u_btn_nort (
    .clk   (clk),
    .Reset (Reset),
    .d     (BTN_NORT),
    .rise  (press)
  );

  // pend_q: a SERVE-state update is out and not yet acknowledged
  assign tick_ok  = frame_tick &&
    (state_q == ST_PLAY ||
     (state_q == ST_SERVE && !pend_q));
  assign tick_bad = frame_tick &&
    (state_q == ST_WAIT_UPD ||
     (state_q == ST_SERVE && pend_q));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    ovr_d   = ovr_q | tick_bad;
    pend_d  = 1'b0;
    upd_d   = tick_ok;
`ifdef PONG_AUTOSERVE_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        pend_d = tick_ok | (pend_q & ~upd_done);
`ifdef PONG_AUTOSERVE_EN
        cnt_d = cnt_q + CW'(frame_tick);
        if (press || (frame_tick && cnt_q == LAST)) begin
          state_d = ST_PLAY;
          pend_d  = 1'b0;
        end
`else
        if (press) begin
          state_d = ST_PLAY;
          pend_d  = 1'b0;
        end
`endif
      end
      ST_PLAY: begin
        if (frame_tick) state_d = ST_WAIT_UPD;
      end
      ST_WAIT_UPD: begin
        if (upd_done) begin
          state_d = ST_POINT;
          unique case (1'b1)
            miss_left && !miss_right: begin
              if (sr_q < WIN) sr_d = sr_q + 1'b1;
              dir_d = DIR_LEFT;
            end
            miss_right && !miss_left: begin
              if (sl_q < WIN) sl_d = sl_q + 1'b1;
              dir_d = DIR_RIGHT;
            end
            miss_left && miss_right: ;
            default: state_d = ST_PLAY;
          endcase
        end
      end
      ST_POINT: begin
        if (sl_q == WIN || sr_q == WIN)
          state_d = ST_GAMEOVER;
        else
          state_d = ST_SERVE;
      end
      ST_GAMEOVER: begin
        if (press) begin
          sl_d    = '0;
          sr_d    = '0;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bc_d = (state_d == ST_IDLE) ||
           (state_d == ST_SERVE) ||
           (state_d == ST_GAMEOVER);
    go_d = (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      upd_q   <= 1'b0;
      bc_q    <= 1'b1;
      dir_q   <= DIR_RIGHT;
      sl_q    <= '0;
      sr_q    <= '0;
      go_q    <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
`ifdef PONG_AUTOSERVE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      upd_q   <= upd_d;
      bc_q    <= bc_d;
      dir_q   <= dir_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      go_q    <= go_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
`ifdef PONG_AUTOSERVE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign upd_en        = upd_q;
  assign ball_center   = bc_q;
  assign serve_dir     = dir_q;
  assign score_l       = sl_q;
  assign score_r       = sr_q;
  assign game_over     = go_q;
  assign frame_overrun = ovr_q;
  assign state_o       = state_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-level game sequencer for the VGA pong design. Sits between the VGA timing generator and the ball/paddle datapath. Owns serve, play, point and game-over sequencing and both scores. Fires exactly one datapath update per video frame, during vertical blanking, so the rendered frame never tears.

## Interface
- `WIN_SCORE`, 5: points needed to win; must be 1..15.
- `SCORE_W`, 4: score counter width.
- `SERVE_FRAMES`, 60: frames of auto-serve delay (only used under `PONG_AUTOSERVE_EN`).
- `clk` in 1: system clock; the only clock.
- `Reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `BTN_NORT` in 1: serve/restart button, level, already debounced and synchronized.
- `upd_done` in 1: one-cycle pulse from the datapath when its per-frame update has finished.
- `miss_left` in 1: ball passed the left paddle; sampled only with `upd_done`.
- `miss_right` in 1: ball passed the right paddle; sampled only with `upd_done`.
- `upd_en` out 1: one-cycle pulse commanding one ball/paddle update.
- `ball_center` out 1: level; holds the ball at screen centre.
- `serve_dir` out 1: 0 = serve toward the left player, 1 = toward the right player.
- `score_l` out SCORE_W: left player score.
- `score_r` out SCORE_W: right player score.
- `game_over` out 1: level, high in GAMEOVER.
- `frame_overrun` out 1: sticky error flag.
- `state_o` out 3: current state encoding, for LEDs and debug.

## Operation
- States:
  - IDLE=0
  - SERVE=1
  - PLAY=2
  - WAIT_UPD=3
  - POINT=4
  - GAMEOVER=5
- `BTN_NORT` is registered once. A press is its rising edge: the registered value was 0 and the current value is 1.
- IDLE: `ball_center`=1. A press moves to SERVE.
- SERVE: `ball_center`=1. The exit to PLAY depends on the build configuration (see Configuration). Paddles still update, so `frame_tick` produces `upd_en` here too.
- PLAY: `frame_tick` pulses `upd_en` and moves to WAIT_UPD.
- WAIT_UPD, when `upd_done` arrives:
  - neither miss: back to PLAY.
  - `miss_left` only: right player scores, `serve_dir`←0, go to POINT.
  - `miss_right` only: left player scores, `serve_dir`←1, go to POINT.
  - both misses: no score, `serve_dir` unchanged, go to POINT.
- POINT lasts one cycle. If either score equals `WIN_SCORE`, go to GAMEOVER; otherwise go to SERVE.
- GAMEOVER: `ball_center`=1 and `game_over`=1. A press clears both scores and moves to SERVE.
- Scores saturate at `WIN_SCORE` and never wrap.
- A `frame_tick` that arrives in WAIT_UPD, or while the SERVE update is still pending, is dropped and sets `frame_overrun`. Only `Reset` clears `frame_overrun`.
- `upd_done` in any state other than WAIT_UPD or SERVE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `upd_en`=0
  - `ball_center`=1
  - `serve_dir`=1
  - both scores 0
  - `game_over`=0
  - `frame_overrun`=0
- `Reset` in mid-update returns to IDLE on the next edge. Any outstanding `upd_done` is then ignored.
- `upd_en` is registered: it goes high the cycle after `frame_tick` is sampled and lasts exactly one cycle.
- Score registers update on the edge that samples `upd_done`, so new scores are visible the following cycle.
- A press arriving on the same cycle as `frame_tick` in SERVE is honoured; that frame's update still issues.

## Configuration
- `PONG_AUTOSERVE_EN` defined:
  - SERVE counts `frame_tick`s.
  - After `SERVE_FRAMES` ticks, or on a press, it goes to PLAY.
  - The counter clears on entry to SERVE.
- `PONG_AUTOSERVE_EN` undefined:
  - Only a press leaves SERVE; no frame counter is built.
  - `SERVE_FRAMES` is ignored.

## Structure
- Shared package `pong_pkg` holds:
  - the state enum and its 3-bit encodings
  - the `serve_dir` constants LEFT=0 and RIGHT=1
  - the default `WIN_SCORE`
- One sub-module, `pong_edge_det`: registered rising-edge detector for `BTN_NORT`. Reusable for `BTN_EAST`/`BTN_WEST`.
- Everything else is a single FSM plus counters in `pong_game_ctrl`.

## Test plan
- Reset, then a press, then 3 `frame_tick`s, then a press: state goes 0→1→2. Each tick yields one `upd_en` exactly 1 cycle later. `ball_center` drops to 0 in PLAY.
- In PLAY, `frame_tick` then `upd_done` with `miss_left`=1: `score_r`=1, `serve_dir`=0, state passes through POINT (4) for 1 cycle, then SERVE.
- Five right-player points: after the fifth, state is GAMEOVER, `game_over`=1 and `score_r`=5 (no further increment). A press clears the scores and moves to SERVE.
- `upd_done` with both misses: scores unchanged, `serve_dir` unchanged, back to SERVE.
- A second `frame_tick` before `upd_done` in WAIT_UPD: no second `upd_en`; `frame_overrun`=1, and it stays 1 until `Reset`.
- With `PONG_AUTOSERVE_EN` and `SERVE_FRAMES`=3: SERVE→PLAY on the cycle after the 3rd tick with no press. Without the macro, SERVE holds indefinitely until a press.
